algo_nr1w_ref: RTL



---
 rtl/algo_ref_pkg.sv | 18 +
 rtl/algo_nr1w_ref_if.sv | 34 +++
 rtl/algo_ref_dly.sv | 33 +++
 rtl/algo_nr1w_ref.sv | 105 ++++++++++
 4 files changed

// File: rtl/algo_ref_pkg.sv
// algo_ref_pkg: shared types and address helpers for the NR1W reference model
package algo_ref_pkg;

    typedef enum logic {INIT, READY} state_t;

    function automatic int addr_bank(int addr, int nrow);
        return addr / nrow;
    endfunction

    function automatic int addr_row(int addr, int nrow);
        return addr % nrow;
    endfunction

    function automatic int pack_padr(int bank, int row, int bitvrow);
        return (bank << bitvrow) | row;
    endfunction

endpackage

// File: rtl/algo_nr1w_ref_if.sv
// algo_nr1w_ref_if: read/write/inject bus of the NR1W reference memory
interface algo_nr1w_ref_if #(
    parameter int NUMRDPT = 2,
    parameter int WIDTH   = 4,
    parameter int BITADDR = 4,
    parameter int BITVBNK = 2,
    parameter int BITVROW = 2,
    parameter int BITPADR = BITVBNK + 1 + BITVROW
);
    logic                       ready;
    logic [NUMRDPT-1:0]         read;
    logic [NUMRDPT*BITADDR-1:0] rd_adr;
    logic [NUMRDPT-1:0]         read_vld;
    logic [NUMRDPT*WIDTH-1:0]   read_dout;
    logic [NUMRDPT-1:0]         read_serr;
    logic [NUMRDPT-1:0]         read_derr;
    logic [NUMRDPT*BITPADR-1:0] read_padr;
    logic                       write;
    logic [BITADDR-1:0]         wr_adr;
    logic [WIDTH-1:0]           din;
    logic                       inject;
    logic [BITVBNK:0]           inj_bank;
    logic [BITVROW-1:0]         inj_row;

    modport master (
        input  ready, read_vld, read_dout, read_serr, read_derr, read_padr,
        output read, rd_adr, write, wr_adr, din, inject, inj_bank, inj_row
    );

    modport slave (
        output ready, read_vld, read_dout, read_serr, read_derr, read_padr,
        input  read, rd_adr, write, wr_adr, din, inject, inj_bank, inj_row
    );
endinterface

// File: rtl/algo_ref_dly.sv
// algo_ref_dly: DEPTH-stage valid+payload delay line with async clear
module algo_ref_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);
    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    // shift valid and payload one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];
endmodule

// File: rtl/algo_nr1w_ref.sv
// algo_nr1w_ref: multi-read / single-write reference memory with error map and init sweep
module algo_nr1w_ref import algo_ref_pkg::*; #(
    parameter int NUMRDPT     = 2,
    parameter int WIDTH       = 4,
    parameter int NUMADDR     = 16,
    parameter int BITADDR     = 4,
    parameter int NUMVBNK     = 4,
    parameter int BITVBNK     = 2,
    parameter int NUMVROW     = 4,
    parameter int BITVROW     = 2,
    parameter int MEM_DELAY   = 1,
    parameter int RDWR_BYPASS = 0,
    parameter int BITPADR     = BITVBNK + 1 + BITVROW
) (
    input logic clk,
    input logic rst,
    algo_nr1w_ref_if.slave bus
);
    localparam int PW = WIDTH + 2 + BITPADR;

    state_t             state_q;
    logic [BITADDR-1:0] cnt_q;
    logic [WIDTH-1:0]   mem_q [NUMADDR];
    logic [NUMVBNK:0]   err_q [NUMVROW];
    logic               active;
    logic               wr_ok;
    logic               inj_ok;
    logic [BITVBNK-1:0] wr_bank;
    logic [BITVROW-1:0] wr_row;

    assign active  = state_q == READY;
    assign bus.ready = active;
    assign wr_ok   = active && bus.write && int'(bus.wr_adr) < NUMADDR;
    assign inj_ok  = active && bus.inject && int'(bus.inj_bank) <= NUMVBNK;
    assign wr_bank = BITVBNK'(addr_bank(int'(bus.wr_adr), NUMVROW));
    assign wr_row  = BITVROW'(addr_row(int'(bus.wr_adr), NUMVROW));

    // init sweep counter; leaves INIT after the last address has been cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= (!active && int'(cnt_q) == NUMADDR - 1) ? READY : state_q;
            cnt_q   <= active ? cnt_q : cnt_q + 1'b1;
        end
    end

    // storage: zero during the sweep, then writes clear and injections set error bits (inject last so it wins)
    always_ff @(posedge clk) begin
        if (!active) begin
            mem_q[cnt_q] <= '0;
            if (int'(cnt_q) < NUMVROW) err_q[BITVROW'(cnt_q)] <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[bus.wr_adr]          <= bus.din;
                err_q[wr_row][{1'b0, wr_bank}] <= 1'b0;
                err_q[wr_row][NUMVBNK]     <= 1'b0;
            end
            if (inj_ok) err_q[bus.inj_row][bus.inj_bank] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUMRDPT; p++) begin : g_rd
        logic [BITADDR-1:0] a;
        logic [BITVBNK-1:0] b;
        logic [BITVROW-1:0] r;
        logic [NUMVBNK:0]   e;
        logic [BITVBNK:0]   lo;
        logic [WIDTH-1:0]   dat;
        logic               take;
        logic               vld;
        logic [PW-1:0]      pay_d;
        logic [PW-1:0]      pay_q;

        assign a    = bus.rd_adr[p*BITADDR +: BITADDR];
        assign take = active && bus.read[p];

        // read lookup against the pre-write error map; lowest flagged bank wins the physical address
        always_comb begin
            b   = BITVBNK'(addr_bank(int'(a), NUMVROW));
            r   = BITVROW'(addr_row(int'(a), NUMVROW));
            e   = err_q[r];
            lo  = {1'b0, b};
            for (int k = NUMVBNK; k >= 0; k--) if (e[k]) lo = (BITVBNK+1)'(k);
            dat = (RDWR_BYPASS != 0 && wr_ok && bus.wr_adr == a) ? bus.din : mem_q[a];
            pay_d = (take && int'(a) < NUMADDR)
                  ? {dat, |e, $countones(e) > 1, BITPADR'(pack_padr(int'(lo), int'(r), BITVROW))}
                  : '0;
        end

        algo_ref_dly #(.DEPTH(MEM_DELAY), .W(PW)) u_dly (
            .clk   (clk),
            .rst   (rst),
            .vld_i (take),
            .dat_i (pay_d),
            .vld_o (vld),
            .dat_o (pay_q)
        );

        assign bus.read_vld[p] = vld;
        assign {bus.read_dout[p*WIDTH +: WIDTH], bus.read_serr[p], bus.read_derr[p],
                bus.read_padr[p*BITPADR +: BITPADR]} = pay_q;
    end
endmodule
